// File: rtl/axi_led_pkg.sv
// Shared definitions for the AXI4-Lite LED controller: register map,
// mode encoding, response codes, FSM state types and small helpers.
package axi_led_pkg;

  // Register index, decoded from addr[3:2]
  localparam logic [1:0] REG_LED_DATA = 2'd0;  // 0x0
  localparam logic [1:0] REG_MODE     = 2'd1;  // 0x4
  localparam logic [1:0] REG_PERIOD   = 2'd2;  // 0x8
  localparam logic [1:0] REG_STATUS   = 2'd3;  // 0xC

  // MODE bit0 encoding
  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_BLINK  = 1'b1;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel FSM: W_ADDR = AW captured, W_DATA = W captured
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  // Read channel FSM
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Replace the bytes of old_val selected by strb with those of new_val
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

  // Mask with the low n bits set; keeps unused LED_DATA bits at zero
  function automatic logic [31:0] led_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[i] = (i < n);
    return m;
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink timer: counts 0..period-1 while enabled and toggles the phase at
// each wrap. A zero period parks the timer with phase high; restart puts
// the count back to zero with phase high so a new setting starts cleanly.
module led_blink_timer
  import axi_led_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic        restart,
  output logic        phase
);

  logic [31:0] r_cnt;
  logic        r_phase;

  // Counter and phase register; restart and zero period take priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (restart || (period == 32'd0)) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (enable) begin
      // >= rather than == so a count that is already past the end still wraps
      if (r_cnt >= (period - 32'd1)) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/axi_led_ctrl.sv
// AXI4-Lite slave driving a bank of LEDs, either statically or blinking
// with a programmable half-period. Independent write and read FSMs; the
// write commits on the edge that completes the second of AW/W.
module axi_led_ctrl
  import axi_led_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_LED            = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // write response channel
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  // LED drive
  output logic [NUM_LED-1:0]              o_LED
);

  localparam logic [31:0] LED_MASK = led_mask(NUM_LED);

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  wr_state_t                     r_wstate;
  wr_state_t                     w_wstate_next;
  rd_state_t                     r_rstate;
  rd_state_t                     w_rstate_next;

  logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]                   r_wdata;
  logic [3:0]                    r_wstrb;
  logic [1:0]                    r_bresp;

  logic [31:0]                   r_led_data;
  logic                          r_mode;
  logic [31:0]                   r_period;
  logic [NUM_LED-1:0]            r_led;

  logic [31:0]                   r_rdata;
  logic [1:0]                    r_rresp;

  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_ar_hs;
  logic                          w_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_wr_addr;
  logic [31:0]                   w_wr_data;
  logic [3:0]                    w_wr_strb;
  logic [1:0]                    w_wr_idx;
  logic                          w_wr_bad;
  logic                          w_rd_bad;
  logic                          w_wr_ok;
  logic                          w_blink_restart;
  logic                          w_phase;
  logic                          w_wr_busy;
  logic [31:0]                   w_rd_data;
  logic                          w_unused;

  // ---------------------------------------------------------------------
  // Handshakes and channel outputs, all decoded from FSM state
  // ---------------------------------------------------------------------
  assign S_AXI_AWREADY = (r_wstate == W_IDLE) || (r_wstate == W_DATA);
  assign S_AXI_WREADY  = (r_wstate == W_IDLE) || (r_wstate == W_ADDR);
  assign S_AXI_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = (r_rstate == R_IDLE);
  assign S_AXI_RVALID  = (r_rstate == R_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign o_LED         = r_led;

  assign w_aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs    = S_AXI_WVALID  && S_AXI_WREADY;
  assign w_ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_wr_busy = (r_wstate != W_IDLE);

  // Fields used at the commit edge: live bus value if that handshake
  // happens now, otherwise the copy captured earlier
  assign w_wr_addr = w_aw_hs ? S_AXI_AWADDR : r_awaddr;
  assign w_wr_data = w_w_hs  ? S_AXI_WDATA  : r_wdata;
  assign w_wr_strb = w_w_hs  ? S_AXI_WSTRB  : r_wstrb;
  assign w_wr_idx  = w_wr_addr[3:2];

  // Addresses beyond the 16-byte window are errors
  generate
    if (C_S_AXI_ADDR_WIDTH > 4) begin : g_addr_hi
      assign w_wr_bad = |w_wr_addr[C_S_AXI_ADDR_WIDTH-1:4];
      assign w_rd_bad = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
    end else begin : g_addr_exact
      assign w_wr_bad = 1'b0;
      assign w_rd_bad = 1'b0;
    end
  endgenerate

  assign w_wr_ok         = w_commit && !w_wr_bad;
  assign w_blink_restart = w_wr_ok &&
                           ((w_wr_idx == REG_MODE) || (w_wr_idx == REG_PERIOD));

  // Protection bits and byte-lane address bits carry no meaning here
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_wr_addr[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------
  // Write state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_wstate <= W_IDLE;
    else                r_wstate <= w_wstate_next;
  end

  // Write next-state and commit strobe
  always_comb begin
    w_wstate_next = r_wstate;
    w_commit      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_next = W_RESP;
          w_commit      = 1'b1;
        end else if (w_aw_hs) begin
          w_wstate_next = W_ADDR;
        end else if (w_w_hs) begin
          w_wstate_next = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_w_hs) begin
          w_wstate_next = W_RESP;
          w_commit      = 1'b1;
        end
      end
      W_DATA: begin
        if (w_aw_hs) begin
          w_wstate_next = W_RESP;
          w_commit      = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  // Capture AW and W fields on their handshakes, and the response at commit
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_bad ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Register file update at the commit edge; STATUS is read-only
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_led_data <= '0;
      r_mode     <= MODE_STATIC;
      r_period   <= '0;
    end else if (w_wr_ok) begin
      case (w_wr_idx)
        REG_LED_DATA: r_led_data <= strb_merge(r_led_data, w_wr_data, w_wr_strb) & LED_MASK;
        REG_MODE:     if (w_wr_strb[0]) r_mode <= w_wr_data[0];
        REG_PERIOD:   r_period   <= strb_merge(r_period, w_wr_data, w_wr_strb);
        default:      ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  // Read state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_rstate <= R_IDLE;
    else                r_rstate <= w_rstate_next;
  end

  // Read next-state
  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (S_AXI_ARVALID) w_rstate_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY)  w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // Read mux from current register contents (pre-write on a shared edge)
  always_comb begin
    w_rd_data = '0;
    if (!w_rd_bad) begin
      case (S_AXI_ARADDR[3:2])
        REG_LED_DATA: w_rd_data = r_led_data;
        REG_MODE:     w_rd_data = {31'd0, r_mode};
        REG_PERIOD:   w_rd_data = r_period;
        REG_STATUS:   w_rd_data = {30'd0, w_wr_busy, w_phase};
        default:      w_rd_data = '0;
      endcase
    end
  end

  // Register read data and response on the AR handshake; held until RREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_rd_bad ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // ---------------------------------------------------------------------
  // Blink timer and LED drive
  // ---------------------------------------------------------------------
  led_blink_timer u_timer (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .enable  (r_mode == MODE_BLINK),
    .period  (r_period),
    .restart (w_blink_restart),
    .phase   (w_phase)
  );

  // Registered LED output, gated by the blink phase in blink mode
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_led <= '0;
    end else if (r_mode == MODE_BLINK) begin
      r_led <= r_led_data[NUM_LED-1:0] & {NUM_LED{w_phase}};
    end else begin
      r_led <= r_led_data[NUM_LED-1:0];
    end
  end

endmodule

// File: doc/axi_led_ctrl.md
AXI_LED_CTRL -- requirements
Module: axi_led_ctrl

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, fixed AXI4-Lite data width; only 32 is legal.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, AXI address width; minimum 4.
REQ-003 SHALL have parameter NUM_LED, default 4, LED count; legal range 1..32.
REQ-004 SHALL have port S_AXI_ACLK, in, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port S_AXI_ARESETN, in, 1, reset; asynchronous, active-low.
REQ-006 SHALL have ports S_AXI_AWADDR/AWPROT/AWVALID (in; ADDR_W/3/1) and S_AXI_AWREADY (out, 1), the write address channel; AWPROT is ignored.
REQ-007 SHALL have ports S_AXI_WDATA/WSTRB/WVALID (in; 32/4/1) and S_AXI_WREADY (out, 1), the write data channel.
REQ-008 SHALL have ports S_AXI_BRESP (out, 2), S_AXI_BVALID (out, 1) and S_AXI_BREADY (in, 1), the write response channel.
REQ-009 SHALL have ports S_AXI_ARADDR/ARPROT/ARVALID (in; ADDR_W/3/1) and S_AXI_ARREADY (out, 1), the read address channel; ARPROT is ignored.
REQ-010 SHALL have ports S_AXI_RDATA (out, 32), S_AXI_RRESP (out, 2), S_AXI_RVALID (out, 1) and S_AXI_RREADY (in, 1), the read data channel.
REQ-011 SHALL have port o_LED, out, NUM_LED, the registered LED drive.

Function
REQ-012 Register map, decoded on addr[3:2]: 0x0 LED_DATA (rw), 0x4 MODE (rw; bit0 1=blink, 0=static), 0x8 PERIOD (rw, clock cycles per half-blink), 0xC STATUS (ro; bit0 blink phase, bit1 write-FSM busy).
REQ-013 Any address with addr[ADDR_W-1:4] nonzero SHALL return RESP=SLVERR and leave registers unchanged; reads of it return 0.
REQ-014 Write FSM states SHALL be W_IDLE, W_ADDR (AW captured), W_DATA (W captured) and W_RESP; AWREADY=1 in W_IDLE/W_DATA and WREADY=1 in W_IDLE/W_ADDR, driven from state only.
REQ-015 The AW and W handshakes SHALL be accepted in either order or on the same edge; the edge completing the second handshake is the commit edge, and the FSM goes to W_RESP.
REQ-016 At the commit edge, bytes enabled by WSTRB SHALL be written; unused LED_DATA bits above NUM_LED read 0; STATUS writes return OKAY and have no effect.
REQ-017 BVALID SHALL be 1 in W_RESP and held with a stable BRESP until BREADY; the FSM then returns to W_IDLE; no new AW/W is accepted in W_RESP.
REQ-018 Read FSM states SHALL be R_IDLE (ARREADY=1) and R_DATA; on the AR handshake, RDATA/RRESP are registered and RVALID=1 the next cycle, held stable until RREADY.
REQ-019 A read and a write to the same register completing on the same edge SHALL return the pre-write value.
REQ-020 Blink counter: CNT counts 0..PERIOD-1; at PERIOD-1, CNT wraps to 0 and the phase toggles; counting occurs only when MODE=1.
REQ-021 PERIOD=0 SHALL hold CNT at 0 and force phase=1; a write to PERIOD or MODE SHALL clear CNT to 0 and set phase=1 at the commit edge.
REQ-022 o_LED SHALL be LED_DATA[NUM_LED-1:0] when MODE=0, and LED_DATA & {NUM_LED{phase}} when MODE=1; registered, it updates one cycle after the commit edge.

Reset
REQ-023 On ARESETN=0, without waiting for a clock: LED_DATA=0, MODE=0, PERIOD=0, CNT=0, phase=1, o_LED=0, both FSMs idle, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
REQ-024 Reset asserted mid-transaction SHALL abort it with no register change; after release, AWREADY, WREADY and ARREADY are 1 in the first cycle.

Structure
REQ-025 Register offsets, MODE encoding, RESP codes (OKAY=2'b00, SLVERR=2'b10) and FSM state encodings SHALL live in shared package axi_led_pkg.
REQ-026 The blink counter/phase logic SHALL be sub-module led_blink_timer (inputs enable, period, restart; output phase).

Verification
REQ-027 Release reset; write 0x5 to 0x0 with AW and W together -> BVALID with OKAY; o_LED=4'b0101 one cycle after commit.
REQ-028 W presented 3 cycles before AW, data 0xA, to 0x0 -> WREADY handshake first, commit on the AW edge, o_LED=4'b1010; repeat with AW first, same result.
REQ-029 Write PERIOD=4, MODE=1, LED_DATA=0xF -> o_LED alternates 0xF/0x0 every 4 cycles; STATUS bit0 tracks the phase.
REQ-030 Write 0xDEADBEEF to 0x10 -> BRESP=SLVERR, registers unchanged; read 0x10 -> RRESP=SLVERR, RDATA=0.
REQ-031 Hold BREADY=0 for 5 cycles -> BVALID stays 1 and the next AW is not accepted; read 0x0 with RREADY delayed -> RDATA stable until handshake.
REQ-032 Assert ARESETN=0 in W_ADDR state -> all outputs reach reset values immediately; the pending write is lost.
